// File: rtl/wb_arbiter.sv
// wb_arbiter: two-port write-back arbiter with port-1 starvation guard; define WB_ARB_FWD_EN for forwarding outputs
module wb_arbiter #(
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  input  logic [4:0]  p0_dest,
  input  logic [31:0] p0_data,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_dest,
  input  logic [31:0] p1_data,
  output logic        p1_ready,
  output logic        rf_load,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_in,
  input  logic [4:0]  fwd_src_a,
  input  logic [4:0]  fwd_src_b,
  output logic        fwd_hit_a,
  output logic        fwd_hit_b,
  output logic [31:0] fwd_data_a,
  output logic [31:0] fwd_data_b
);
  typedef enum logic {PRIO0, PRIO1} state_t;
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  state_t      state;
  logic [3:0]  wait_cnt;
  logic        p1_starved;
  logic        wb_go;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  // a lone request is always granted; a conflict goes to the port holding priority
  always_comb begin
    p0_ready   = !reset && p0_valid && (!p1_valid || state == PRIO0);
    p1_ready   = !reset && p1_valid && (!p0_valid || state == PRIO1);
    p1_starved = p1_valid && !p1_ready;
    wb_dest    = p1_ready ? p1_dest : p0_dest;
    wb_data    = p1_ready ? p1_data : p0_data;
    wb_go      = (p0_ready || p1_ready) && wb_dest != 5'd0;
  end
  // priority FSM, starvation counter and registered register-file write port
  always_ff @(posedge clk)
    if (reset) begin
      state    <= PRIO0;
      wait_cnt <= '0;
      rf_load  <= 1'b0;
      rf_dest  <= '0;
      rf_in    <= '0;
    end else begin
      if (p1_ready) begin
        wait_cnt <= '0;
        state    <= PRIO0;
      end else if (p1_starved) begin
        wait_cnt <= (wait_cnt == MW) ? wait_cnt : wait_cnt + 4'd1;
        if (wait_cnt >= MW - 4'd1) state <= PRIO1;
      end
      rf_load <= wb_go;
      if (wb_go) begin
        rf_dest <= wb_dest;
        rf_in   <= wb_data;
      end
    end
`ifdef WB_ARB_FWD_EN
  assign fwd_hit_a  = rf_load && fwd_src_a == rf_dest && fwd_src_a != 5'd0;
  assign fwd_hit_b  = rf_load && fwd_src_b == rf_dest && fwd_src_b != 5'd0;
  assign fwd_data_a = fwd_hit_a ? rf_in : '0;
  assign fwd_data_b = fwd_hit_b ? rf_in : '0;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_src_a, fwd_src_b};
  assign fwd_hit_a  = 1'b0;
  assign fwd_hit_b  = 1'b0;
  assign fwd_data_a = '0;
  assign fwd_data_b = '0;
`endif
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 3, legal 1..15; consecutive cycles port 1 may be refused before it takes priority.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  reset input. The block has one clock; reset is synchronous and active-high.
REQ-004 Port: p0_valid, p1_valid  input  1 each  write-back request valid; port 0 is ALU, port 1 is LSU.
REQ-005 Port: p0_dest, p1_dest  input  IR::reg_t (5)  destination register index.
REQ-006 Port: p0_data, p1_data  input  Global::size_t (32)  write-back data.
REQ-007 Port: p0_ready, p1_ready  output  1 each  grant; a transfer occurs when valid and ready are both high in the same cycle.
REQ-008 Port: rf_load  output  1  register-file write enable (registered).
REQ-009 Port: rf_dest  output  IR::reg_t  register-file write index (registered).
REQ-010 Port: rf_in  output  Global::size_t  register-file write data (registered).
REQ-011 Port: fwd_src_a, fwd_src_b  input  IR::reg_t  forwarding query indices (used only with WB_ARB_FWD_EN).
REQ-012 Port: fwd_hit_a, fwd_hit_b  output  1 each  query matches the pending write.
REQ-013 Port: fwd_data_a, fwd_data_b  output  Global::size_t each  forwarded data.

Function
REQ-014 The block shall grant at most one port per cycle; p0_ready and p1_ready are combinational from valids and state, and are never both high.
REQ-015 The block shall have state PRIO0 (port 0 wins a conflict) and PRIO1 (port 1 wins a conflict); a lone valid request is always granted in either state.
REQ-016 wait_cnt shall increment when p1_valid=1 and p1_ready=0, clear when port 1 transfers, hold when p1_valid=0, and saturate at MAX_WAIT.
REQ-017 The block shall move PRIO0->PRIO1 on the edge at which wait_cnt would reach MAX_WAIT; PRIO1->PRIO0 on the edge at which port 1 transfers; otherwise the state holds.
REQ-018 A transfer shall register rf_load=1, rf_dest=dest, rf_in=data on the next edge (latency 1 cycle); with no transfer, rf_load=0 and rf_dest/rf_in hold.
REQ-019 A transfer with dest=0 shall be accepted (ready=1) but produce rf_load=0; rf_dest/rf_in hold.
REQ-020 Requesters shall hold valid, dest and data stable until ready; the arbiter does not buffer refused requests.
REQ-021 The output stage shall never stall; back-to-back transfers every cycle shall be supported.

Reset
REQ-022 On reset=1 at a clock edge: state=PRIO0, wait_cnt=0, rf_load=0, rf_dest=0, rf_in=0.
REQ-023 While reset=1, p0_ready=p1_ready=0; a request in flight is dropped and the requester re-presents it after reset.
REQ-024 fwd_hit_a/b shall read 0 during and after reset until the first valid write.

Configuration
REQ-025 Macro WB_ARB_FWD_EN defined: fwd_hit_x = rf_load and (fwd_src_x == rf_dest) and fwd_src_x != 0; fwd_data_x = rf_in when hit, else 0; combinational.
REQ-026 Macro WB_ARB_FWD_EN undefined: fwd_hit_a/b=0, fwd_data_a/b=0, fwd_src inputs ignored; arbitration unchanged.

Verification
REQ-027 Reset, then p0 only with dest=5, data=0xDEADBEEF -> p0_ready=1 in the same cycle; next cycle rf_load=1, rf_dest=5, rf_in=0xDEADBEEF.
REQ-028 Both ports valid continuously with MAX_WAIT=3 -> port 0 granted for 3 cycles, port 1 granted in cycle 4, port 0 granted in cycle 5; pattern repeats.
REQ-029 p1 only with dest=0, data=0x1234 -> p1_ready=1; next cycle rf_load=0 and rf_dest/rf_in unchanged.
REQ-030 Contention with wait_cnt=2, then reset asserted for 1 cycle -> both ready=0 during reset; afterwards state=PRIO0, wait_cnt=0, and rf_load=0.
REQ-031 WB_ARB_FWD_EN defined: transfer dest=7, data=0x55 with fwd_src_a=7 and fwd_src_b=0 on the next cycle -> fwd_hit_a=1, fwd_data_a=0x55, fwd_hit_b=0. With the macro undefined -> all fwd outputs 0.
